// File: rtl/idma_evt_tracker.sv
`default_nettype none
// idma_evt_tracker -- per-tile iDMA status tracker: outstanding/error counters,
// per-channel state machine, event pulses and a maskable level interrupt. Rev 1.0
module idma_evt_tracker #(
    parameter int CNT_W     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 irq_a2o_busy_i,
    input  logic                 irq_a2o_start_i,
    input  logic                 irq_a2o_done_i,
    input  logic                 irq_a2o_error_i,
    input  logic                 irq_o2a_busy_i,
    input  logic                 irq_o2a_start_i,
    input  logic                 irq_o2a_done_i,
    input  logic                 irq_o2a_error_i,
    input  logic [3:0]           irq_mask_i,
    input  logic [3:0]           irq_ack_i,
    output logic [CNT_W-1:0]     a2o_outstanding_o,
    output logic [CNT_W-1:0]     o2a_outstanding_o,
    output logic [ERR_CNT_W-1:0] a2o_err_cnt_o,
    output logic [ERR_CNT_W-1:0] o2a_err_cnt_o,
    output logic [1:0]           a2o_state_o,
    output logic [1:0]           o2a_state_o,
    output logic                 evt_a2o_done_o,
    output logic                 evt_o2a_done_o,
    output logic                 evt_a2o_err_o,
    output logic                 evt_o2a_err_o,
    output logic [3:0]           pending_o,
    output logic                 irq_o,
    output logic                 overflow_o,
    output logic                 underflow_o,
    output logic                 all_idle_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERROR  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0]     CNT_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    // Channel 0 = AXI2OBI, channel 1 = OBI2AXI; pending/mask bits are {err,drained} per channel.
    logic [1:0] start_w, done_w, err_w, busy_w, ack_drn_w, ack_err_w;

    assign start_w   = {irq_o2a_start_i, irq_a2o_start_i};
    assign done_w    = {irq_o2a_done_i,  irq_a2o_done_i};
    assign err_w     = {irq_o2a_error_i, irq_a2o_error_i};
    assign busy_w    = {irq_o2a_busy_i,  irq_a2o_busy_i};
    assign ack_drn_w = {irq_ack_i[2],    irq_ack_i[0]};
    assign ack_err_w = {irq_ack_i[3],    irq_ack_i[1]};

    logic [CNT_W-1:0]     cnt_q     [2];
    logic [CNT_W-1:0]     cnt_d     [2];
    logic [ERR_CNT_W-1:0] err_cnt_q [2];
    logic [ERR_CNT_W-1:0] err_cnt_d [2];
    state_e               state_q   [2];
    state_e               state_d   [2];
    logic [1:0]           evt_done_q, evt_done_d;
    logic [1:0]           evt_err_q,  evt_err_d;
    logic [3:0]           pending_q,  pending_d;
    logic [3:0]           pend_set_w;
    logic                 irq_q, irq_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 all_idle_q, all_idle_d;

    always_comb begin
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        pend_set_w = '0;
        evt_done_d = '0;
        evt_err_d  = '0;
        for (int ch = 0; ch < 2; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            // A start and a done in the same cycle cancel: no count change, no flags, no drain.
            if (start_w[ch] && !done_w[ch]) begin
                if (cnt_q[ch] == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                end
            end else if (done_w[ch] && !start_w[ch]) begin
                if (cnt_q[ch] == '0) begin
                    unf_d = 1'b1;
                end else begin
                    cnt_d[ch]      = cnt_q[ch] - CNT_W'(1);
                    evt_done_d[ch] = (cnt_q[ch] == CNT_W'(1));
                end
            end

            evt_err_d[ch] = err_w[ch];
            err_cnt_d[ch] = err_cnt_q[ch];
            if (err_w[ch] && (err_cnt_q[ch] != ERR_MAX)) begin
                err_cnt_d[ch] = err_cnt_q[ch] + ERR_CNT_W'(1);
            end

            state_d[ch] = state_q[ch];
            if (err_w[ch]) begin
                state_d[ch] = ST_ERROR;
            end else if ((state_q[ch] != ST_ERROR) || ack_err_w[ch]) begin
                state_d[ch] = (cnt_d[ch] != '0) ? ST_ACTIVE : ST_IDLE;
            end

            pend_set_w[2*ch]   = evt_done_d[ch];
            pend_set_w[2*ch+1] = err_w[ch];
        end

        // Set wins over acknowledge in the same cycle.
        pending_d  = (pending_q & ~irq_ack_i) | pend_set_w;
        irq_d      = |(pending_q & irq_mask_i);
        all_idle_d = (cnt_d[0] == '0) && (cnt_d[1] == '0) && (busy_w == 2'b00) &&
                     (state_d[0] == ST_IDLE) && (state_d[1] == ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int ch = 0; ch < 2; ch++) begin
                cnt_q[ch]     <= '0;
                err_cnt_q[ch] <= '0;
                state_q[ch]   <= ST_IDLE;
            end
            evt_done_q <= '0;
            evt_err_q  <= '0;
            pending_q  <= '0;
            irq_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            all_idle_q <= 1'b1;
        end else if (clear_i) begin
            for (int ch = 0; ch < 2; ch++) begin
                cnt_q[ch]     <= '0;
                err_cnt_q[ch] <= '0;
                state_q[ch]   <= ST_IDLE;
            end
            evt_done_q <= '0;
            evt_err_q  <= '0;
            pending_q  <= '0;
            irq_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            all_idle_q <= 1'b1;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                cnt_q[ch]     <= cnt_d[ch];
                err_cnt_q[ch] <= err_cnt_d[ch];
                state_q[ch]   <= state_d[ch];
            end
            evt_done_q <= evt_done_d;
            evt_err_q  <= evt_err_d;
            pending_q  <= pending_d;
            irq_q      <= irq_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            all_idle_q <= all_idle_d;
        end
    end

    assign a2o_outstanding_o = cnt_q[0];
    assign o2a_outstanding_o = cnt_q[1];
    assign a2o_err_cnt_o     = err_cnt_q[0];
    assign o2a_err_cnt_o     = err_cnt_q[1];
    assign a2o_state_o       = state_q[0];
    assign o2a_state_o       = state_q[1];
    assign evt_a2o_done_o    = evt_done_q[0];
    assign evt_o2a_done_o    = evt_done_q[1];
    assign evt_a2o_err_o     = evt_err_q[0];
    assign evt_o2a_err_o     = evt_err_q[1];
    assign pending_o         = pending_q;
    assign irq_o             = irq_q;
    assign overflow_o        = ovf_q;
    assign underflow_o       = unf_q;
    assign all_idle_o        = all_idle_q;

endmodule
`default_nettype wire

// File: tb/tb_idma_evt_tracker.sv
`default_nettype none
// tb_idma_evt_tracker -- directed stimulus, cycle-level reference model and literal checks.
module tb_idma_evt_tracker;

    localparam int MAXC   = 15;
    localparam int ERRMAX = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       a_busy = 0, a_start = 0, a_done = 0, a_err = 0;
    logic       o_busy = 0, o_start = 0, o_done = 0, o_err = 0;
    logic [3:0] mask = 4'b0;
    logic [3:0] ack = 4'b0;

    logic [3:0] a2o_cnt, o2a_cnt;
    logic [7:0] a2o_ec, o2a_ec;
    logic [1:0] a2o_st, o2a_st;
    logic       evt_ad, evt_od, evt_ae, evt_oe;
    logic [3:0] pending;
    logic       irq, ovf, unf, idle;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    idma_evt_tracker #(.CNT_W(4), .ERR_CNT_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr),
        .irq_a2o_busy_i(a_busy), .irq_a2o_start_i(a_start),
        .irq_a2o_done_i(a_done), .irq_a2o_error_i(a_err),
        .irq_o2a_busy_i(o_busy), .irq_o2a_start_i(o_start),
        .irq_o2a_done_i(o_done), .irq_o2a_error_i(o_err),
        .irq_mask_i(mask), .irq_ack_i(ack),
        .a2o_outstanding_o(a2o_cnt), .o2a_outstanding_o(o2a_cnt),
        .a2o_err_cnt_o(a2o_ec), .o2a_err_cnt_o(o2a_ec),
        .a2o_state_o(a2o_st), .o2a_state_o(o2a_st),
        .evt_a2o_done_o(evt_ad), .evt_o2a_done_o(evt_od),
        .evt_a2o_err_o(evt_ae), .evt_o2a_err_o(evt_oe),
        .pending_o(pending), .irq_o(irq),
        .overflow_o(ovf), .underflow_o(unf), .all_idle_o(idle)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers, updated from the inputs seen at each rising edge.
    int       m_cnt [2];
    int       m_err [2];
    int       m_st  [2];
    bit       m_evd [2];
    bit       m_eve [2];
    bit [3:0] m_pend;
    bit       m_irq, m_ovf, m_unf, m_idle;

    task automatic m_reset();
        for (int c = 0; c < 2; c++) begin
            m_cnt[c] = 0; m_err[c] = 0; m_st[c] = 0; m_evd[c] = 0; m_eve[c] = 0;
        end
        m_pend = 4'b0; m_irq = 0; m_ovf = 0; m_unf = 0; m_idle = 1;
    endtask

    task automatic m_step();
        bit s [2];
        bit d [2];
        bit e [2];
        bit b [2];
        bit ae [2];
        bit [3:0] set;
        s[0] = a_start; s[1] = o_start;
        d[0] = a_done;  d[1] = o_done;
        e[0] = a_err;   e[1] = o_err;
        b[0] = a_busy;  b[1] = o_busy;
        ae[0] = ack[1]; ae[1] = ack[3];
        set = 4'b0;
        m_irq = |(m_pend & mask);
        for (int c = 0; c < 2; c++) begin
            m_evd[c] = 0;
            if (s[c] && !d[c]) begin
                if (m_cnt[c] == MAXC) m_ovf = 1;
                else m_cnt[c] = m_cnt[c] + 1;
            end else if (d[c] && !s[c]) begin
                if (m_cnt[c] == 0) m_unf = 1;
                else begin
                    m_cnt[c] = m_cnt[c] - 1;
                    m_evd[c] = (m_cnt[c] == 0);
                end
            end
            m_eve[c] = e[c];
            if (e[c] && m_err[c] < ERRMAX) m_err[c] = m_err[c] + 1;
            if (e[c]) m_st[c] = 2;
            else if (m_st[c] != 2 || ae[c]) m_st[c] = (m_cnt[c] > 0) ? 1 : 0;
            set[2*c]   = m_evd[c];
            set[2*c+1] = e[c];
        end
        m_pend = (m_pend & ~ack) | set;
        m_idle = (m_cnt[0] == 0) && (m_cnt[1] == 0) && (m_st[0] == 0) && (m_st[1] == 0) && !b[0] && !b[1];
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n || clr) m_reset();
            else m_step();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("m_a2o_cnt",  a2o_cnt, m_cnt[0]);
                chk("m_o2a_cnt",  o2a_cnt, m_cnt[1]);
                chk("m_a2o_err",  a2o_ec,  m_err[0]);
                chk("m_o2a_err",  o2a_ec,  m_err[1]);
                chk("m_a2o_st",   a2o_st,  m_st[0]);
                chk("m_o2a_st",   o2a_st,  m_st[1]);
                chk("m_evt_ad",   evt_ad,  m_evd[0]);
                chk("m_evt_od",   evt_od,  m_evd[1]);
                chk("m_evt_ae",   evt_ae,  m_eve[0]);
                chk("m_evt_oe",   evt_oe,  m_eve[1]);
                chk("m_pending",  pending, m_pend);
                chk("m_irq",      irq,     m_irq);
                chk("m_ovf",      ovf,     m_ovf);
                chk("m_unf",      unf,     m_unf);
                chk("m_all_idle", idle,    m_idle);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        a_start = 0; a_done = 0; a_err = 0;
        o_start = 0; o_done = 0; o_err = 0;
        ack = 4'b0; clr = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        cmp_en = 1'b1;
        #1 rst_n = 1'b1;
        tick(); tick();
        chk("rst_a2o_cnt", a2o_cnt, 0);
        chk("rst_o2a_st",  o2a_st, 0);
        chk("rst_pending", pending, 0);
        chk("rst_irq",     irq, 0);
        chk("rst_idle",    idle, 1);

        // Drain with drained interrupt enabled
        mask = 4'b0001;
        for (int i = 1; i <= 3; i++) begin
            a_start = 1; tick();
            chk("drain_up", a2o_cnt, i);
        end
        for (int i = 2; i >= 0; i--) begin
            a_done = 1; tick();
            chk("drain_down", a2o_cnt, i);
        end
        chk("drain_evt", evt_ad, 1);
        chk("drain_pend", pending, 4'b0001);
        chk("drain_irq_n1", irq, 0);
        tick();
        chk("drain_irq_n2", irq, 1);
        chk("drain_evt_1cyc", evt_ad, 0);
        ack = 4'b0001; tick();
        chk("ack_pend", pending, 0);
        tick();
        chk("ack_irq", irq, 0);

        // Simultaneous start and done on o2a
        o_start = 1; tick();
        chk("sim_cnt1", o2a_cnt, 1);
        o_start = 1; o_done = 1; tick();
        chk("sim_cnt", o2a_cnt, 1);
        chk("sim_noevt", evt_od, 0);
        chk("sim_state", o2a_st, 1);
        o_done = 1; tick();
        chk("sim_drain", evt_od, 1);
        ack = 4'b0100; tick();

        // Error on a2o with two outstanding
        a_start = 1; tick();
        a_start = 1; tick();
        a_err = 1; tick();
        chk("err_state", a2o_st, 2);
        chk("err_cnt", a2o_ec, 1);
        chk("err_evt", evt_ae, 1);
        chk("err_pend", pending[1], 1);
        tick();
        chk("err_evt_1cyc", evt_ae, 0);
        a_done = 1; tick();
        a_done = 1; tick();
        chk("err_drain_cnt", a2o_cnt, 0);
        chk("err_drain_evt", evt_ad, 1);
        chk("err_stays", a2o_st, 2);
        ack = 4'b0010; tick();
        chk("err_ack_idle", a2o_st, 0);
        ack = 4'b0001; tick();

        // Saturation
        repeat (16) begin a_start = 1; tick(); end
        chk("sat_cnt", a2o_cnt, 15);
        chk("sat_ovf", ovf, 1);
        o_done = 1; tick();
        chk("sat_unf", unf, 1);
        chk("sat_o2a_cnt", o2a_cnt, 0);
        repeat (256) begin o_err = 1; tick(); end
        chk("sat_err", o2a_ec, 255);
        ack = 4'b1000; tick();
        chk("sat_ack_idle", o2a_st, 0);

        // Set beats ack; masking
        o_err = 1; ack = 4'b1000; tick();
        chk("prio_pend3", pending[3], 1);
        mask = 4'b0000; tick(); tick();
        chk("mask_off_irq", irq, 0);
        mask = 4'b1000; tick();
        chk("mask_on_irq", irq, 1);

        // Synchronous clear mid-transfer, with a start discarded in the clear cycle
        clr = 1; tick();
        repeat (5) begin a_start = 1; tick(); end
        a_err = 1; tick();
        chk("clr_pre_cnt", a2o_cnt, 5);
        chk("clr_pre_pend", pending[1], 1);
        clr = 1; a_start = 1; tick();
        chk("clr_cnt", a2o_cnt, 0);
        chk("clr_pend", pending, 0);
        chk("clr_state", a2o_st, 0);
        chk("clr_errcnt", a2o_ec, 0);
        chk("clr_ovf", ovf, 0);
        chk("clr_idle", idle, 1);

        // Asynchronous reset mid-transfer
        repeat (5) begin a_start = 1; tick(); end
        a_err = 1; tick();
        chk("rst_pre_cnt", a2o_cnt, 5);
        rst_n = 1'b0;
        #2;
        chk("arst_cnt", a2o_cnt, 0);
        chk("arst_pend", pending, 0);
        chk("arst_irq", irq, 0);
        chk("arst_idle", idle, 1);
        #1 rst_n = 1'b1;
        tick();
        chk("arst_idle2", idle, 1);
        a_done = 1; tick();
        chk("arst_unf", unf, 1);

        // Busy input only affects all_idle
        a_busy = 1; tick();
        chk("busy_idle", idle, 0);
        a_busy = 0; tick();
        chk("busy_idle_back", idle, 1);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
